ssd: RTL and testbench



---
 rtl/ssd.sv | 133 +++++++++++++
 tb/tb_ssd.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ssd.sv
// ---------------------------------------------------------------------------
// ssd : hex seven-segment display driver, one instance per digit.
//
// Decodes a 4-bit value (0..F) into segment drive lines a..g plus a decimal
// point, with blanking, lamp test and 16-level PWM brightness control.
//
// Parameters
//   ACTIVE_LOW  1 = a lit segment drives 0 (common anode)
//               0 = a lit segment drives 1 (common cathode)
//
// Build option
//   SSD_OUTPUT_REG_EN  when defined, segments/dp come from flops that reset
//                      to "off" and lag the inputs by one clk. When
//                      undefined, the decode path is purely combinational.
//
// Ports
//   clk        in   1  system clock; advances pwm_cnt and the output register
//   rst_n      in   1  asynchronous active-low reset
//   no         in   4  value to display, 0x0..0xF
//   blank      in   1  1 = all segments and dp off (highest priority)
//   lamp_test  in   1  1 = all segments and dp on (still PWM gated)
//   dp_in      in   1  1 = decimal point requested on
//   duty       in   4  brightness, 0 = 1/16 on .. 15 = always on
//   segments   out  7  segment drive, bit 6 = a .. bit 0 = g
//   dp         out  1  decimal-point drive, same polarity as segments
// ---------------------------------------------------------------------------
module ssd #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] no,
   input  logic       blank,
   input  logic       lamp_test,
   input  logic       dp_in,
   input  logic [3:0] duty,
   output logic [6:0] segments,
   output logic       dp
);

   // XOR mask turning "lit" (active-high) into pin polarity; it is also the
   // pin value of an unlit segment.
   localparam logic [6:0] POL_MASK = {7{ACTIVE_LOW}};

   logic [3:0] pwm_cnt;
   logic [6:0] pattern_on;   // active-high lit pattern from the decode table
   logic [6:0] seg_on;       // lit segments after priority and PWM gating
   logic       dp_on;
   logic [6:0] seg_drv;      // pin-polarity versions
   logic       dp_drv;

   // Free-running brightness counter; wraps 15 -> 0 naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= 4'd0;
      end else begin
         pwm_cnt <= pwm_cnt + 4'd1;
      end
   end

   // Table written in active-low form (as on a common-anode datasheet), then
   // inverted so the rest of the logic works in "1 = lit".
   always_comb begin
      pattern_on = 7'h00;
      case (no)
         4'h0: pattern_on = ~7'b0000001;
         4'h1: pattern_on = ~7'b1001111;
         4'h2: pattern_on = ~7'b0010010;
         4'h3: pattern_on = ~7'b0000110;
         4'h4: pattern_on = ~7'b1001100;
         4'h5: pattern_on = ~7'b0100100;
         4'h6: pattern_on = ~7'b0100000;
         4'h7: pattern_on = ~7'b0001111;
         4'h8: pattern_on = ~7'b0000000;
         4'h9: pattern_on = ~7'b0000100;
         4'hA: pattern_on = ~7'b0001000;
         4'hB: pattern_on = ~7'b1100000;
         4'hC: pattern_on = ~7'b0110001;
         4'hD: pattern_on = ~7'b1000010;
         4'hE: pattern_on = ~7'b0110000;
         4'hF: pattern_on = ~7'b0111000;
         default: pattern_on = 7'h00;
      endcase
   end

   // Priority blank > lamp_test > decode, then PWM gate on the registered
   // counter so a duty change simply applies from the next comparison.
   always_comb begin
      seg_on = 7'h00;
      dp_on  = 1'b0;
      if (blank) begin
         seg_on = 7'h00;
         dp_on  = 1'b0;
      end else if (lamp_test) begin
         seg_on = 7'h7F;
         dp_on  = 1'b1;
      end else begin
         seg_on = pattern_on;
         dp_on  = dp_in;
      end
      if (pwm_cnt > duty) begin
         seg_on = 7'h00;
         dp_on  = 1'b0;
      end
   end

   assign seg_drv = seg_on ^ POL_MASK;
   assign dp_drv  = dp_on ^ ACTIVE_LOW;

`ifdef SSD_OUTPUT_REG_EN
   // Registered pins: glitch-free, one clk of latency, off during reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         segments <= POL_MASK;
         dp       <= ACTIVE_LOW;
      end else begin
         segments <= seg_drv;
         dp       <= dp_drv;
      end
   end
`else
   // Combinational pins; reset forces "off" immediately without a clock.
   always_comb begin
      segments = POL_MASK;
      dp       = ACTIVE_LOW;
      if (rst_n) begin
         segments = seg_drv;
         dp       = dp_drv;
      end
   end
`endif

endmodule

// File: tb/tb_ssd.sv
// ---------------------------------------------------------------------------
// tb_ssd : self-checking bench for ssd.
//
// Two instances share all inputs: dut_al (ACTIVE_LOW=1) and dut_ah
// (ACTIVE_LOW=0). Expected values are the active-low pin images {seg, dp};
// the common-cathode instance must show their bitwise inverse.
// The driver pushes expectations into exp_q and raises chk_valid; the monitor
// pops and compares on the falling clk edge while chk_valid is high.
// Works for both builds: under SSD_OUTPUT_REG_EN the driver waits one extra
// rising edge after changing inputs before asking for a comparison.
// ---------------------------------------------------------------------------
module tb_ssd;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] no;
   logic       blank;
   logic       lamp_test;
   logic       dp_in;
   logic [3:0] duty;
   logic [6:0] seg_al, seg_ah;
   logic       dp_al, dp_ah;

   always #5 clk = ~clk;

   ssd #(.ACTIVE_LOW(1'b1)) dut_al (
      .clk(clk), .rst_n(rst_n), .no(no), .blank(blank), .lamp_test(lamp_test),
      .dp_in(dp_in), .duty(duty), .segments(seg_al), .dp(dp_al)
   );

   ssd #(.ACTIVE_LOW(1'b0)) dut_ah (
      .clk(clk), .rst_n(rst_n), .no(no), .blank(blank), .lamp_test(lamp_test),
      .dp_in(dp_in), .duty(duty), .segments(seg_ah), .dp(dp_ah)
   );

   // Reference brightness counter (free-running, async reset to 0).
   logic [3:0] m_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_cnt <= 4'd0;
      else        m_cnt <= m_cnt + 4'd1;
   end

   // Active-low segment table, a..g = bit 6..0.
   logic [6:0] tbl [16];
   initial begin
      tbl[0]  = 7'b0000001; tbl[1]  = 7'b1001111; tbl[2]  = 7'b0010010; tbl[3]  = 7'b0000110;
      tbl[4]  = 7'b1001100; tbl[5]  = 7'b0100100; tbl[6]  = 7'b0100000; tbl[7]  = 7'b0001111;
      tbl[8]  = 7'b0000000; tbl[9]  = 7'b0000100; tbl[10] = 7'b0001000; tbl[11] = 7'b1100000;
      tbl[12] = 7'b0110001; tbl[13] = 7'b1000010; tbl[14] = 7'b0110000; tbl[15] = 7'b0111000;
   end

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   string      name_q[$];
   logic       chk_valid = 1'b0;
   int         chk_cnt   = 0;
   int         pass_cnt  = 0;
   int         lit_seen  = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got seg=%b dp=%b, expected seg=%b dp=%b",
                    name, act[7:1], act[0], exp[7:1], exp[0]);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Monitor
   always @(negedge clk) begin
      if (chk_valid) begin
         if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL scoreboard: comparison requested with empty expected queue");
         end else begin
            logic [7:0] e;
            string      n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check({n, "/al"}, {seg_al, dp_al}, e);
            check({n, "/ah"}, {seg_ah, dp_ah}, ~e);
            if (seg_al != 7'h7F) lit_seen++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at posedge+1; consumes exactly one clock, returns at posedge+1.
   task automatic push_check(input string name, input logic [6:0] seg, input logic dpv);
      exp_q.push_back({seg, dpv});
      name_q.push_back(name);
      chk_valid = 1'b1;
      @(negedge clk);
      #1 chk_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
`ifdef SSD_OUTPUT_REG_EN
      @(posedge clk);
      #1;
`endif
   endtask

   task automatic show(input logic [3:0] v, input logic d);
      no    = v;
      dp_in = d;
      settle();
      push_check($sformatf("decode_%h", v), tbl[v], ~d);
   endtask

   task automatic pwm_run(input logic [3:0] d);
      logic [3:0] c;
      no    = 4'h0;
      dp_in = 1'b0;
      duty  = d;
      repeat (2) @(posedge clk);
      #1;
      lit_seen = 0;
      for (int i = 0; i < 16; i++) begin
`ifdef SSD_OUTPUT_REG_EN
         c = m_cnt - 4'd1;
`else
         c = m_cnt;
`endif
         if (c <= d) push_check($sformatf("pwm_d%0d_c%0d", d, c), tbl[0], 1'b1);
         else        push_check($sformatf("pwm_d%0d_c%0d", d, c), 7'h7F, 1'b1);
      end
      check_int($sformatf("pwm_lit_count_d%0d", d), lit_seen, int'(d) + 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n     = 1'b0;
      no        = 4'h0;
      blank     = 1'b0;
      lamp_test = 1'b0;
      dp_in     = 1'b0;
      duty      = 4'd15;
      @(posedge clk);
      #1;
      push_check("reset_state", 7'h7F, 1'b1);
      rst_n = 1'b1;

      // Sweep 0..7, dp_in follows bit 0
      for (int v = 0; v < 8; v++) show(4'(v), v[0]);

      // Reset mid-sweep with 8 shown: off at once, then back to all-lit
      no    = 4'h8;
      dp_in = 1'b0;
      rst_n = 1'b0;
      #1;
      push_check("reset_mid", 7'h7F, 1'b1);
      rst_n = 1'b1;
      settle();
      push_check("reset_release", 7'b0000000, 1'b1);

      for (int v = 8; v < 16; v++) show(4'(v), v[0]);

      // blank beats lamp_test
      no = 4'h8; blank = 1'b1; lamp_test = 1'b1;
      settle();
      push_check("blank_and_lamp", 7'h7F, 1'b1);
      blank = 1'b0;
      settle();
      push_check("lamp_test", 7'b0000000, 1'b0);
      no = 4'h1; dp_in = 1'b0;
      settle();
      push_check("lamp_test_no1", 7'b0000000, 1'b0);
      lamp_test = 1'b0; dp_in = 1'b1;
      settle();
      push_check("no1_dp", 7'b1001111, 1'b0);
      blank = 1'b1; duty = 4'd0;
      settle();
      push_check("blank_dim", 7'h7F, 1'b1);
      blank = 1'b0;

      // Brightness
      pwm_run(4'd3);
      pwm_run(4'd0);
      pwm_run(4'd15);

      // Drain and report
      if (exp_q.size() != 0) begin
         chk_cnt++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
